// File: rtl/sram_like_responder.sv
// sram_like_responder
//
// Responder end of the sram-like data interface. It accepts address
// handshakes, performs byte-strobed writes or word reads on an internal
// word-addressed memory, and returns one in-order response per accepted
// request a fixed LATENCY cycles after the accept edge.
//
// Parameters:
//   ADDR_W  - word-index width; the memory holds 2**ADDR_W 32-bit words
//   DEPTH   - maximum outstanding requests (>= LATENCY, >= 1)
//   LATENCY - cycles from the accept edge to data_ok (>= 1)
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-high
//   req     in   request valid, held until addr_ok
//   wr      in   1 = write, 0 = read
//   size    in   access size, informational only (wstrb governs writes)
//   addr    in   byte address; word index is addr[ADDR_W+1:2]
//   wstrb   in   write byte-lane enables
//   wdata   in   write data
//   addr_ok out  request accepted when req && addr_ok
//   data_ok out  one-cycle response pulse, in accept order
//   rdata   out  read data with data_ok, otherwise 0 (also 0 for writes)
//   pending out  outstanding request count

module sram_like_responder #(
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         wr,
  input  logic [1:0]                   size,
  input  logic [31:0]                  addr,
  input  logic [3:0]                   wstrb,
  input  logic [31:0]                  wdata,
  output logic                         addr_ok,
  output logic                         data_ok,
  output logic [31:0]                  rdata,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_DUE  = AGE_W'(LATENCY);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] word_idx;

  logic [31:0]       data_q  [DEPTH];
  logic [AGE_W-1:0]  age_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              pop;

  // size and the address bits outside the word index do not affect behaviour.
  logic unused_inputs;
  assign unused_inputs = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign word_idx = addr[ADDR_W+1:2];

  // Acceptance looks only at the registered count, so a response leaving
  // in the same cycle does not open a slot until the next cycle.
  assign addr_ok = !reset && (count != CNT_FULL);
  assign accept  = req && addr_ok;

  // Entries are pushed in order and age together, so the head is always
  // the oldest and the only one that can be due. Reset masks a due head
  // so that discarded responses never appear on data_ok.
  assign pop     = !reset && valid_q[rd_ptr] && (age_q[rd_ptr] == AGE_DUE);
  assign data_ok = pop;
  assign rdata   = pop ? data_q[rd_ptr] : 32'd0;
  assign pending = count;

  // Memory has no reset: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (age_q[i] != AGE_DUE)) begin
          age_q[i] <= age_q[i] + AGE_ONE;
        end
      end

      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end

      // The push slot is never the popped slot: a push needs count < DEPTH,
      // which makes wr_ptr point at a free entry.
      if (accept) begin
        valid_q[wr_ptr] <= 1'b1;
        age_q[wr_ptr]   <= AGE_ONE;
        data_q[wr_ptr]  <= wr ? 32'd0 : mem[word_idx];
        wr_ptr          <= ptr_inc(wr_ptr);
      end

      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder. Two instances share the request fields:
// dut_a uses the default timing (LATENCY 2), dut_b uses LATENCY 4 so that
// DEPTH == LATENCY and the full condition can be reached.

module tb_sram_like_responder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int LAT_A  = 2;
  localparam int LAT_B  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  logic        addr_ok_a, data_ok_a, addr_ok_b, data_ok_b;
  logic [31:0] rdata_a, rdata_b;
  logic [2:0]  pending_a, pending_b;

  always #5 clk = ~clk;

  sram_like_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_a), .data_ok(data_ok_a),
    .rdata(rdata_a), .pending(pending_a)
  );

  sram_like_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_b), .data_ok(data_ok_b),
    .rdata(rdata_b), .pending(pending_b)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] ref_mem [2][4096];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  // The memory holds 2**ADDR_W words; higher address bits wrap around.
  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << ADDR_W));
  endfunction

  // Drive one request and hold it until accepted. The expected response is
  // queued at the accept point: it is due LATENCY cycles later.
  task automatic issue(input int sel, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output int acc_cyc, output int waits);
    exp_t e;
    int   idx;
    logic ok;
    wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
    waits   = 0;
    acc_cyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = (sel == 0) ? addr_ok_a : addr_ok_b;
      if (ok) begin
        acc_cyc = cyc;
        break;
      end
      waits++;
    end
    if (acc_cyc < 0) begin
      fail_now($sformatf("accept_timeout sel=%0d addr=%h: no addr_ok in 50 cycles", sel, a));
    end else begin
      idx   = word_of(a);
      e.due = cyc + ((sel == 0) ? LAT_A : LAT_B);
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) ref_mem[sel][idx][8*i +: 8] = d[8*i +: 8];
        e.data = 32'd0;
      end else begin
        e.data = ref_mem[sel][idx];
      end
      if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    @(posedge clk);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon(input int sel, input logic dok, input logic [31:0] rd);
    exp_t  e;
    string tag;
    int    qsz;
    tag = (sel == 0) ? "A" : "B";
    qsz = (sel == 0) ? q_a.size() : q_b.size();
    if (reset) begin
      check({"data_ok_in_reset_", tag}, {31'd0, dok}, 32'd0);
      return;
    end
    if (dok) begin
      if (qsz == 0) begin
        fail_now({"unexpected_data_ok_", tag, ": data_ok=1, expected no response"});
      end else begin
        e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
        check({"rdata_", tag}, rd, e.data);
        check({"latency_", tag}, cyc, e.due);
      end
    end else begin
      check({"rdata_idle_", tag}, rd, 32'd0);
      if (qsz != 0) begin
        e = (sel == 0) ? q_a[0] : q_b[0];
        if (e.due <= cyc) begin
          fail_now($sformatf("missing_data_ok_%s: data_ok=0, response due at cycle %0d", tag, e.due));
          if (sel == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, data_ok_a, rdata_a);
    mon(1, data_ok_b, rdata_b);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c5, c6, w0, w1, tmp;
    int sel, idx, gap;
    logic [31:0] a;

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    wr = 1'b0; size = 2'd0; addr = 32'd0; wstrb = 4'd0; wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("addr_ok_in_reset_A", {31'd0, addr_ok_a}, 32'd0);
    check("addr_ok_in_reset_B", {31'd0, addr_ok_b}, 32'd0);
    check("pending_in_reset_A", {29'd0, pending_a}, 32'd0);
    check("pending_in_reset_B", {29'd0, pending_b}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("addr_ok_after_reset_A", {31'd0, addr_ok_a}, 32'd1);
    check("addr_ok_after_reset_B", {31'd0, addr_ok_b}, 32'd1);
    check("pending_after_reset_A", {29'd0, pending_a}, 32'd0);
    check("data_ok_after_reset_A", {31'd0, data_ok_a}, 32'd0);
    @(posedge clk);
    #1;

    // Write then read
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, c0, w0);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, c1, w1);
    check("wr_rd_addr_ok_wait_wr", w0, 0);
    check("wr_rd_addr_ok_wait_rd", w1, 0);
    check("wr_rd_back_to_back", c1, c0 + 1);
    idle(4);

    // Byte strobes: expect 0x11BB33DD from the model
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344, c0, w0);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, c0, w0);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, c0, w0);
    idle(4);

    // wstrb = 0 still answers and leaves the word untouched
    issue(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, c0, w0);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, c0, w0);
    idle(4);

    // Aliasing: 0x4000 maps to word 0
    issue(0, 1'b1, 32'h0000_4000, 4'hF, 32'h5A5A5A5A, c0, w0);
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, c0, w0);
    idle(4);

    // Streaming on A: 16 writes then 16 reads, addr_ok never low
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b1, 32'(i * 4), 4'hF, 32'(i * 4), c0, w0);
      check("stream_wr_wait", w0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b0, 32'(i * 4), 4'h0, 32'h0, c0, w0);
      check("stream_rd_wait", w0, 0);
    end
    idle(4);

    // Prepare B's memory
    for (int i = 0; i < 16; i++) issue(1, 1'b1, 32'(i * 4), 4'hF, 32'(i * 4), c0, w0);
    idle(6);

    // Full: DEPTH = LATENCY = 4, six back-to-back reads
    issue(1, 1'b0, 32'h0, 4'h0, 32'h0, c1, w0);
    check("full_wait_1", w0, 0);
    for (int i = 1; i < 4; i++) begin
      issue(1, 1'b0, 32'(i * 4), 4'h0, 32'h0, tmp, w0);
      check("full_wait_2to4", w0, 0);
    end
    @(negedge clk);
    check("full_addr_ok", {31'd0, addr_ok_b}, 32'd0);
    check("full_pending", {29'd0, pending_b}, 32'd4);
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, c5, w0);
    check("full_5th_accept_cycle", c5, c1 + LAT_B + 1);
    issue(1, 1'b0, 32'h14, 4'h0, 32'h0, c6, w0);
    check("full_6th_accept_cycle", c6, c5 + 1);
    idle(8);

    // Reset mid-flight on B: reset rises one cycle before the first response
    issue(1, 1'b0, 32'h4, 4'h0, 32'h0, c0, w0);
    issue(1, 1'b0, 32'h8, 4'h0, 32'h0, c0, w0);
    issue(1, 1'b0, 32'hC, 4'h0, 32'h0, c0, w0);
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    repeat (3) begin
      @(negedge clk);
      check("reset_midflight_data_ok", {31'd0, data_ok_b}, 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_midflight_pending", {29'd0, pending_b}, 32'd0);
    check("reset_midflight_addr_ok", {31'd0, addr_ok_b}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("after_reset_data_ok", {31'd0, data_ok_b}, 32'd0);
    end
    @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h10, 4'h0, 32'h0, c0, w0);
    issue(0, 1'b0, 32'h3C, 4'h0, 32'h0, c0, w0);
    idle(6);

    // Randomized traffic over the initialised 16-word region
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      a   = {$urandom() & 32'hFFFF_C000} | 32'(idx * 4) | 32'($urandom_range(0, 3));
      issue(sel, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom(), c0, w0);
      gap = int'($urandom_range(0, 3));
      if (gap == 3) idle(int'($urandom_range(1, 5)));
    end

    // Drain
    for (int k = 0; k < 30; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clk);
    end
    if (q_a.size() != 0 || q_b.size() != 0)
      fail_now($sformatf("drain: %0d/%0d responses still outstanding, expected 0", q_a.size(), q_b.size()));
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
